// File: rtl/zeroheti_obi_demux.sv
`default_nettype none
// ============================================================================
//  Module      : zeroheti_obi_demux
//  Description : One-to-N OBI address demultiplexer. It decodes each request
//                against a rule table and keeps a bounded number of
//                transactions in flight. Unmapped accesses are served by an
//                internal error responder. The first faulting address is
//                captured for software.
//  Revision    : 1.0 - initial release
// ============================================================================
module zeroheti_obi_demux #(
  parameter int unsigned            NUM_MGR_PORTS = 6,
  parameter int unsigned            NUM_RULES     = 6,
  parameter int unsigned            NUM_MAX_TRANS = 4,
  parameter int unsigned            ADDR_WIDTH    = 32,
  parameter int unsigned            DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0]  ERR_DATA      = 32'hBADCAB1E,
  localparam int unsigned           IDX_WIDTH     = (NUM_MGR_PORTS > 1) ? $clog2(NUM_MGR_PORTS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // address map
  input  logic [NUM_RULES*ADDR_WIDTH-1:0] rule_start_i,
  input  logic [NUM_RULES*ADDR_WIDTH-1:0] rule_end_i,
  input  logic [NUM_RULES*IDX_WIDTH-1:0]  rule_idx_i,
  input  logic [NUM_RULES-1:0]            rule_en_i,
  // upstream (subordinate side of this block)
  input  logic                            sbr_req_i,
  output logic                            sbr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]           sbr_addr_i,
  input  logic                            sbr_we_i,
  input  logic [DATA_WIDTH/8-1:0]         sbr_be_i,
  input  logic [DATA_WIDTH-1:0]           sbr_wdata_i,
  output logic                            sbr_rvalid_o,
  output logic [DATA_WIDTH-1:0]           sbr_rdata_o,
  output logic                            sbr_err_o,
  // downstream (manager side of this block)
  output logic [NUM_MGR_PORTS-1:0]        mgr_req_o,
  input  logic [NUM_MGR_PORTS-1:0]        mgr_gnt_i,
  output logic [ADDR_WIDTH-1:0]           mgr_addr_o,
  output logic                            mgr_we_o,
  output logic [DATA_WIDTH/8-1:0]         mgr_be_o,
  output logic [DATA_WIDTH-1:0]           mgr_wdata_o,
  input  logic [NUM_MGR_PORTS-1:0]        mgr_rvalid_i,
  input  logic [NUM_MGR_PORTS*DATA_WIDTH-1:0] mgr_rdata_i,
  input  logic [NUM_MGR_PORTS-1:0]        mgr_err_i,
  // fault capture
  output logic                            fault_valid_o,
  output logic [ADDR_WIDTH-1:0]           fault_addr_o,
  input  logic                            fault_clr_i
);

  // Target encoding has one extra value for the internal error responder.
  localparam int unsigned TGT_W = $clog2(NUM_MGR_PORTS + 1);
  localparam int unsigned CNT_W = $clog2(NUM_MAX_TRANS + 1);

  localparam logic [TGT_W-1:0] c_err_idx   = TGT_W'(NUM_MGR_PORTS);
  localparam logic [CNT_W-1:0] c_max_trans = CNT_W'(NUM_MAX_TRANS);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_err_pending;
  logic [TGT_W-1:0]      r_last_tgt;
  logic                  r_fault_valid;
  logic [ADDR_WIDTH-1:0] r_fault_addr;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [NUM_RULES-1:0]  w_rule_hit;
  logic [TGT_W-1:0]      w_rule_tgt [NUM_RULES];
  logic [TGT_W-1:0]      w_tgt;
  logic                  w_tgt_is_err;

  for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
    logic [ADDR_WIDTH-1:0] w_start;
    logic [ADDR_WIDTH-1:0] w_end;
    logic [TGT_W-1:0]      w_idx;

    assign w_start = rule_start_i[r*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_end   = rule_end_i[r*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_idx   = TGT_W'(rule_idx_i[r*IDX_WIDTH +: IDX_WIDTH]);

    assign w_rule_hit[r] = rule_en_i[r] && (sbr_addr_i >= w_start) && (sbr_addr_i <= w_end);
    // A rule pointing past the last real port is routed to the error responder.
    assign w_rule_tgt[r] = (w_idx < c_err_idx) ? w_idx : c_err_idx;
  end

  // Priority select: scan from the top so the lowest-numbered hit is applied last.
  always_comb begin
    w_tgt = c_err_idx;
    for (int r = int'(NUM_RULES) - 1; r >= 0; r--) begin
      if (w_rule_hit[r]) begin
        w_tgt = w_rule_tgt[r];
      end
    end
  end

  assign w_tgt_is_err = (w_tgt == c_err_idx);

  // --------------------------------------------------------------------------
  // Issue
  // --------------------------------------------------------------------------
  logic [NUM_MGR_PORTS-1:0] w_tgt_oh;
  logic [NUM_MGR_PORTS-1:0] w_last_oh;
  logic                     w_allowed;
  logic                     w_tgt_gnt;
  logic                     w_accept;

  for (genvar p = 0; p < NUM_MGR_PORTS; p++) begin : g_port_sel
    assign w_tgt_oh[p]  = (w_tgt == TGT_W'(p));
    assign w_last_oh[p] = (r_last_tgt == TGT_W'(p));
  end

  // Only one target may be in flight at a time, so responses return in order.
  assign w_allowed = (r_cnt < c_max_trans) && ((r_cnt == '0) || (w_tgt == r_last_tgt));

  // The error responder accepts immediately; real ports forward their grant.
  assign w_tgt_gnt = w_tgt_is_err ? 1'b1 : |(mgr_gnt_i & w_tgt_oh);

  assign mgr_req_o = {NUM_MGR_PORTS{w_allowed && sbr_req_i}} & w_tgt_oh;
  assign sbr_gnt_o = w_allowed && sbr_req_i && w_tgt_gnt;
  assign w_accept  = sbr_gnt_o;

  assign mgr_addr_o  = sbr_addr_i;
  assign mgr_we_o    = sbr_we_i;
  assign mgr_be_o    = sbr_be_i;
  assign mgr_wdata_o = sbr_wdata_i;

  // --------------------------------------------------------------------------
  // Response
  // --------------------------------------------------------------------------
  logic                  w_err_rsp;
  logic                  w_mgr_rsp;
  logic [DATA_WIDTH-1:0] w_mgr_rdata;
  logic                  w_mgr_err;

  assign w_err_rsp = (r_err_pending != '0) && (r_last_tgt == c_err_idx);
  assign w_mgr_rsp = |(mgr_rvalid_i & w_last_oh);

  // Select data and error of the port the outstanding transactions went to.
  always_comb begin
    w_mgr_rdata = '0;
    w_mgr_err   = 1'b0;
    for (int p = 0; p < int'(NUM_MGR_PORTS); p++) begin
      if (w_last_oh[p]) begin
        w_mgr_rdata = mgr_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        w_mgr_err   = mgr_err_i[p];
      end
    end
  end

  // Nothing is forwarded with an empty counter, which drops stale responses
  // after a mid-transaction reset.
  assign sbr_rvalid_o = (r_cnt != '0) && (w_err_rsp || w_mgr_rsp);
  assign sbr_rdata_o  = w_err_rsp ? ERR_DATA : w_mgr_rdata;
  assign sbr_err_o    = sbr_rvalid_o && (w_err_rsp || w_mgr_err);

  // --------------------------------------------------------------------------
  // Outstanding counter and last target register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_last_tgt <= '0;
    end else begin
      if (w_accept) begin
        r_last_tgt <= w_tgt;
      end
      case ({w_accept, sbr_rvalid_o})
        2'b10: if (r_cnt != c_max_trans) r_cnt <= r_cnt + CNT_W'(1);
        2'b01: if (r_cnt != '0)          r_cnt <= r_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Error responder: count requests it accepted and answer one per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_pending <= '0;
    end else begin
      case ({w_accept && w_tgt_is_err, w_err_rsp})
        2'b10: if (r_err_pending != c_max_trans) r_err_pending <= r_err_pending + CNT_W'(1);
        2'b01: r_err_pending <= r_err_pending - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky fault capture: keep the first address; a fault coinciding with a
  // clear is captured rather than lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
    end else if (w_accept && w_tgt_is_err && (!r_fault_valid || fault_clr_i)) begin
      r_fault_valid <= 1'b1;
      r_fault_addr  <= sbr_addr_i;
    end else if (fault_clr_i) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
    end
  end

  assign fault_valid_o = r_fault_valid;
  assign fault_addr_o  = r_fault_addr;

`ifndef SYNTHESIS
  // A response from a port that holds no outstanding transaction is illegal.
  a_rsp_from_other_port : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (r_cnt != '0) |-> ((mgr_rvalid_i & ~w_last_oh) == '0)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_zeroheti_obi_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zeroheti_obi_demux
//  Description : Scoreboard bench for zeroheti_obi_demux with a simple
//                in-order downstream subordinate model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zeroheti_obi_demux;

  localparam int NP = 6;
  localparam int NR = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rule_start;
  logic [NR*AW-1:0] rule_end;
  logic [NR*IW-1:0] rule_idx;
  logic [NR-1:0]    rule_en;
  logic             sbr_req;
  logic             sbr_gnt_o;
  logic [AW-1:0]    sbr_addr;
  logic             sbr_we;
  logic [DW/8-1:0]  sbr_be;
  logic [DW-1:0]    sbr_wdata;
  logic             sbr_rvalid_o;
  logic [DW-1:0]    sbr_rdata_o;
  logic             sbr_err_o;
  logic [NP-1:0]    mgr_req_o;
  logic [NP-1:0]    mgr_gnt;
  logic [AW-1:0]    mgr_addr_o;
  logic             mgr_we_o;
  logic [DW/8-1:0]  mgr_be_o;
  logic [DW-1:0]    mgr_wdata_o;
  logic [NP-1:0]    mgr_rvalid;
  logic [NP*DW-1:0] mgr_rdata;
  logic [NP-1:0]    mgr_err;
  logic             fault_valid_o;
  logic [AW-1:0]    fault_addr_o;
  logic             fault_clr;

  zeroheti_obi_demux dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rule_start_i (rule_start),
    .rule_end_i   (rule_end),
    .rule_idx_i   (rule_idx),
    .rule_en_i    (rule_en),
    .sbr_req_i    (sbr_req),
    .sbr_gnt_o    (sbr_gnt_o),
    .sbr_addr_i   (sbr_addr),
    .sbr_we_i     (sbr_we),
    .sbr_be_i     (sbr_be),
    .sbr_wdata_i  (sbr_wdata),
    .sbr_rvalid_o (sbr_rvalid_o),
    .sbr_rdata_o  (sbr_rdata_o),
    .sbr_err_o    (sbr_err_o),
    .mgr_req_o    (mgr_req_o),
    .mgr_gnt_i    (mgr_gnt),
    .mgr_addr_o   (mgr_addr_o),
    .mgr_we_o     (mgr_we_o),
    .mgr_be_o     (mgr_be_o),
    .mgr_wdata_o  (mgr_wdata_o),
    .mgr_rvalid_i (mgr_rvalid),
    .mgr_rdata_i  (mgr_rdata),
    .mgr_err_i    (mgr_err),
    .fault_valid_o(fault_valid_o),
    .fault_addr_o (fault_addr_o),
    .fault_clr_i  (fault_clr)
  );

  int total = 0;
  int bad   = 0;

  // Expected upstream responses: {err, rdata}
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // --------------------------------------------------------------------------
  // Downstream model: in-order, one-cycle response latency unless held.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]  port;
    logic [31:0] data;
  } ds_t;

  ds_t         ds_q[$];
  logic [NP-1:0] hold;
  logic [DW-1:0] rsp_data [NP];

  always @(posedge clk) begin
    if (!rst_n) begin
      ds_q.delete();
      mgr_rvalid <= '0;
      mgr_rdata  <= '0;
    end else begin
      if (mgr_rvalid != '0) void'(ds_q.pop_front());
      for (int p = 0; p < NP; p++) begin
        if (mgr_req_o[p] && mgr_gnt[p]) ds_q.push_back({3'(p), rsp_data[p]});
      end
      mgr_rvalid <= '0;
      if (ds_q.size() > 0 && !hold[ds_q[0].port]) begin
        mgr_rvalid <= NP'(1) << ds_q[0].port;
        mgr_rdata[int'(ds_q[0].port)*DW +: DW] <= ds_q[0].data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: every upstream response is matched against the scoreboard.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && sbr_rvalid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: actual rdata=%h err=%b required no response", sbr_rdata_o, sbr_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 64'(sbr_rdata_o), 64'(mon_e[31:0]));
        chk("rsp_err", 64'(sbr_err_o), 64'(mon_e[32]));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at posedge + 1)
  // --------------------------------------------------------------------------
  task automatic set_rule(input int r, input logic [31:0] s, input logic [31:0] e,
                          input logic [2:0] idx, input logic en);
    rule_start[r*AW +: AW] = s;
    rule_end[r*AW +: AW]   = e;
    rule_idx[r*IW +: IW]   = idx;
    rule_en[r]             = en;
  endtask

  task automatic issue(input logic [31:0] addr, input logic exp_err, input logic [31:0] exp_data,
                       input logic [NP-1:0] exp_req, output int waits);
    bit granted;
    waits     = 0;
    granted   = 1'b0;
    sbr_req   = 1'b1;
    sbr_addr  = addr;
    sbr_we    = 1'b0;
    sbr_be    = 4'hF;
    sbr_wdata = addr ^ 32'h5A5A_5A5A;
    while (!granted && waits < 40) begin
      @(negedge clk);
      if (sbr_gnt_o) granted = 1'b1;
      else waits++;
    end
    if (granted) begin
      chk("issue_mgr_req", 64'(mgr_req_o), 64'(exp_req));
      exp_q.push_back({exp_err, exp_data});
    end else begin
      total++;
      bad++;
      $display("FAIL issue_timeout: actual no grant for addr %h required grant", addr);
    end
    @(posedge clk);
    #1;
    sbr_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rules();
    rule_start = '0;
    rule_end   = '0;
    rule_idx   = '0;
    rule_en    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int w;
    int w2;
    clear_rules();
    sbr_req   = 1'b0;
    sbr_addr  = '0;
    sbr_we    = 1'b0;
    sbr_be    = '0;
    sbr_wdata = '0;
    fault_clr = 1'b0;
    mgr_gnt   = '1;
    mgr_err   = '0;
    hold      = '0;
    for (int p = 0; p < NP; p++) rsp_data[p] = 32'hA000_0000 | 32'(p);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(sbr_gnt_o), 64'd0);
    chk("rst_rvalid", 64'(sbr_rvalid_o), 64'd0);
    chk("rst_mgr_req", 64'(mgr_req_o), 64'd0);
    chk("rst_fault_valid", 64'(fault_valid_o), 64'd0);
    chk("rst_fault_addr", 64'(fault_addr_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic read routed to port1, one-cycle response
    set_rule(0, 32'h0000_0000, 32'h0000_0FFF, 3'd0, 1'b1);
    set_rule(1, 32'h0000_1000, 32'h0000_1FFF, 3'd1, 1'b1);
    rsp_data[1] = 32'h1234_5678;
    issue(32'h0000_1004, 1'b0, 32'h1234_5678, 6'b000010, w);
    chk("t1_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("t1_rvalid_latency", 64'(sbr_rvalid_o), 64'd1);
    drain();

    // Overlapping rules: lowest index wins
    clear_rules();
    set_rule(0, 32'h0000_0000, 32'h0000_1FFF, 3'd2, 1'b1);
    set_rule(1, 32'h0000_1000, 32'h0000_1FFF, 3'd3, 1'b1);
    rsp_data[2] = 32'h2222_0002;
    rsp_data[3] = 32'h3333_0003;
    issue(32'h0000_1800, 1'b0, 32'h2222_0002, 6'b000100, w);
    drain();

    // Outstanding limit: four in flight to port0, fifth waits for a response
    clear_rules();
    set_rule(0, 32'h0000_0000, 32'h0000_0FFF, 3'd0, 1'b1);
    set_rule(1, 32'h0000_1000, 32'h0000_1FFF, 3'd1, 1'b1);
    hold[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rsp_data[0] = 32'hD000_0000 + 32'(i);
      issue(32'h0000_0010 + 32'(4*i), 1'b0, 32'hD000_0000 + 32'(i), 6'b000001, w);
      chk("t3_grant_immediate", 64'(w), 64'd0);
    end
    rsp_data[0] = 32'hD000_0004;
    fork
      issue(32'h0000_0020, 1'b0, 32'hD000_0004, 6'b000001, w);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("t3_fifth_blocked", 64'(sbr_gnt_o), 64'd0);
        end
        @(posedge clk);
        #1;
        hold[0] = 1'b0;
      end
    join
    drain();

    // Different target blocked while another port has a transaction in flight
    hold[0] = 1'b1;
    rsp_data[0] = 32'h0000_AAAA;
    issue(32'h0000_0040, 1'b0, 32'h0000_AAAA, 6'b000001, w);
    rsp_data[1] = 32'h0000_BBBB;
    fork
      issue(32'h0000_1040, 1'b0, 32'h0000_BBBB, 6'b000010, w2);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("t4_port1_gnt_blocked", 64'(sbr_gnt_o), 64'd0);
          chk("t4_port1_req_blocked", 64'(mgr_req_o), 64'd0);
        end
        @(posedge clk);
        #1;
        hold[0] = 1'b0;
      end
    join
    drain();

    // Error responder: back-to-back unmapped accesses and fault capture
    issue(32'h9000_0000, 1'b1, 32'hBADC_AB1E, 6'b000000, w);
    chk("t5_err_gnt_a", 64'(w), 64'd0);
    issue(32'h9000_0004, 1'b1, 32'hBADC_AB1E, 6'b000000, w);
    chk("t5_err_gnt_b", 64'(w), 64'd0);
    @(negedge clk);
    chk("t5_b2b_rvalid", 64'(sbr_rvalid_o), 64'd1);
    chk("t5_b2b_err", 64'(sbr_err_o), 64'd1);
    @(negedge clk);
    chk("t5_rvalid_done", 64'(sbr_rvalid_o), 64'd0);
    chk("t5_err_idle", 64'(sbr_err_o), 64'd0);
    chk("t5_fault_valid", 64'(fault_valid_o), 64'd1);
    chk("t5_fault_addr", 64'(fault_addr_o), 64'h9000_0000);
    @(posedge clk);
    #1;

    // Clear and new fault in the same cycle: the new fault is captured
    fault_clr = 1'b1;
    issue(32'h9000_0008, 1'b1, 32'hBADC_AB1E, 6'b000000, w);
    fault_clr = 1'b0;
    chk("t5_clr_newfault_valid", 64'(fault_valid_o), 64'd1);
    chk("t5_clr_newfault_addr", 64'(fault_addr_o), 64'h9000_0008);
    drain();

    // Rule with out-of-range port and disabled rule both go to the error responder
    set_rule(2, 32'h0000_2000, 32'h0000_2FFF, 3'd6, 1'b1);
    set_rule(3, 32'h0000_3000, 32'h0000_3FFF, 3'd1, 1'b0);
    issue(32'h0000_2010, 1'b1, 32'hBADC_AB1E, 6'b000000, w);
    issue(32'h0000_3000, 1'b1, 32'hBADC_AB1E, 6'b000000, w);
    drain();
    chk("t5_fault_kept", 64'(fault_addr_o), 64'h9000_0008);
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    chk("t5_cleared_valid", 64'(fault_valid_o), 64'd0);
    chk("t5_cleared_addr", 64'(fault_addr_o), 64'd0);

    // Mid-transaction asynchronous reset with three outstanding
    hold[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(32'h0000_0100 + 32'(4*i), 1'b0, rsp_data[0], 6'b000001, w);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 64'(sbr_gnt_o), 64'd0);
    chk("t6_async_rvalid", 64'(sbr_rvalid_o), 64'd0);
    chk("t6_async_mgr_req", 64'(mgr_req_o), 64'd0);
    chk("t6_async_fault", 64'(fault_valid_o), 64'd0);
    exp_q.delete();
    hold = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_data[1] = 32'h600D_0001;
    issue(32'h0000_1008, 1'b0, 32'h600D_0001, 6'b000010, w);
    chk("t6_post_reset_grant", 64'(w), 64'd0);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
